data_mem_responder: RTL

//  Memory-side responder for the multicycle core's data-memory accesses (LW/SW).

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_array.sv | 23 ++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default widths
// and the wait-state counter width.
package data_mem_responder_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10,
    ST_RSVD = 2'b11
  } state_e;

endpackage

// File: rtl/data_mem_responder_array.sv
// Word storage for the responder: synchronous write, combinational read, no reset
// so contents survive a responder reset.
module dmr_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with fixed wait states over valid/ready request/response
// channels. Define DATA_MEM_RESPONDER_BOUNDS_CHECK_EN to fault addresses >= DEPTH.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              commit;
  logic              cmt_we;
  logic [ADDR_W-1:0] cmt_addr;
  logic [DATA_W-1:0] cmt_wdata;
  logic              cmt_err;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, before the latch is loaded.
  assign cmt_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign cmt_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign cmt_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

`ifdef DATA_MEM_RESPONDER_BOUNDS_CHECK_EN
  assign cmt_err = ({1'b0, cmt_addr} >= AW1'(DEPTH));
`else
  logic unused_hi;
  assign unused_hi = ^cmt_addr[ADDR_W-1:AW];
  assign cmt_err   = 1'b0;
`endif

  assign arr_we = commit && cmt_we && !cmt_err;

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      rdata_d = (cmt_we || cmt_err) ? '0 : arr_rdata;
      err_d   = cmt_err;
    end
  end

  dmr_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (cmt_addr[AW-1:0]),
    .wdata(cmt_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
